imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_ext_pipe_pkg.sv | 25 ++
 rtl/imm_ext_pipe_decode.sv | 46 ++++
 rtl/imm_ext_pipe.sv | 135 +++++++++++++
 tb/tb_imm_ext_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pipe_pkg.sv
// Shared CPU definitions for the immediate-extension pipeline: ImmSrc formats
// and skid-buffer occupancy states.
package imm_ext_pipe_pkg;

   localparam int unsigned IMM_SRC_W  = 3;
   localparam int unsigned BASE_IMM_W = 32;

   typedef enum logic [IMM_SRC_W-1:0] {
      IMM_I    = 3'b000,
      IMM_S    = 3'b001,
      IMM_B    = 3'b010,
      IMM_U    = 3'b011,
      IMM_J    = 3'b100,
      IMM_CSR  = 3'b101,
      IMM_RSV6 = 3'b110,
      IMM_RSV7 = 3'b111
   } imm_src_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

endpackage

// File: rtl/imm_ext_pipe_decode.sv
// Combinational RISC-V immediate extraction; sign-extends from Instr[31] to XLEN,
// zero-extends the CSR uimm, and flags reserved format selects.
module imm_decode
   import imm_ext_pipe_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]          instr_i,
   input  logic [IMM_SRC_W-1:0] imm_src_i,
   output logic [XLEN-1:0]      imm_c,
   output logic                 illegal_c
);

   logic [BASE_IMM_W-1:0] imm32_c;
   logic                  sign_c;
   imm_src_e              src_c;
   logic                  unused_c;

   assign sign_c   = instr_i[31];
   assign src_c    = imm_src_e'(imm_src_i);
   assign unused_c = ^instr_i[6:0];

   always_comb begin
      imm32_c   = '0;
      illegal_c = 1'b0;
      case (src_c)
         IMM_I:   imm32_c = {{20{sign_c}}, instr_i[31:20]};
         IMM_S:   imm32_c = {{20{sign_c}}, instr_i[31:25], instr_i[11:7]};
         IMM_B:   imm32_c = {{19{sign_c}}, instr_i[31], instr_i[7], instr_i[30:25],
                             instr_i[11:8], 1'b0};
         IMM_U:   imm32_c = {instr_i[31:12], 12'b0};
         IMM_J:   imm32_c = {{11{sign_c}}, instr_i[31], instr_i[19:12], instr_i[20],
                             instr_i[30:21], 1'b0};
         IMM_CSR: imm32_c = {27'b0, instr_i[19:15]};
         default: illegal_c = 1'b1;
      endcase
   end

   // Bit 31 of every 32-bit result already carries the right extension bit.
   if (XLEN > BASE_IMM_W) begin : g_wide
      assign imm_c = {{(XLEN-BASE_IMM_W){imm32_c[BASE_IMM_W-1]}}, imm32_c};
   end else begin : g_narrow
      assign imm_c = imm32_c[XLEN-1:0];
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage behind a 2-entry skid buffer (output + skid register);
// in_ready comes straight from a flop so the upstream path stays short.
module imm_ext_pipe
   import imm_ext_pipe_pkg::*;
#(
   parameter int unsigned XLEN              = 32,
   parameter int unsigned INSTRUCTION_WIDTH = 32,
   parameter int unsigned TAG_WIDTH         = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [INSTRUCTION_WIDTH-1:0] Instr,
   input  logic [IMM_SRC_W-1:0]         ImmSrc,
   input  logic [TAG_WIDTH-1:0]         in_tag,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [XLEN-1:0]              ImmExt,
   output logic [TAG_WIDTH-1:0]         out_tag,
   output logic                         out_illegal
);

   skid_state_e          state_q, state_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;
   logic [XLEN-1:0]      out_imm_q, out_imm_d;
   logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
   logic                 out_ill_q, out_ill_d;
   logic [XLEN-1:0]      skid_imm_q, skid_imm_d;
   logic [TAG_WIDTH-1:0] skid_tag_q, skid_tag_d;
   logic                 skid_ill_q, skid_ill_d;

   logic [XLEN-1:0]      dec_imm_c;
   logic                 dec_ill_c;
   logic                 accept_c;
   logic                 drain_c;

   imm_decode #(
      .XLEN (XLEN)
   ) u_imm_decode (
      .instr_i   (Instr[31:0]),
      .imm_src_i (ImmSrc),
      .imm_c     (dec_imm_c),
      .illegal_c (dec_ill_c)
   );

   assign accept_c = in_valid && in_ready_q;
   assign drain_c  = out_valid_q && out_ready;

   // Next-state and payload steering.
   always_comb begin
      state_d    = state_q;
      out_imm_d  = out_imm_q;
      out_tag_d  = out_tag_q;
      out_ill_d  = out_ill_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      skid_ill_d = skid_ill_q;

      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_c) begin
                  state_d   = ST_ONE;
                  out_imm_d = dec_imm_c;
                  out_tag_d = in_tag;
                  out_ill_d = dec_ill_c;
               end
            end
            ST_ONE: begin
               if (accept_c && drain_c) begin
                  out_imm_d = dec_imm_c;
                  out_tag_d = in_tag;
                  out_ill_d = dec_ill_c;
               end else if (accept_c) begin
                  state_d    = ST_FULL;
                  skid_imm_d = dec_imm_c;
                  skid_tag_d = in_tag;
                  skid_ill_d = dec_ill_c;
               end else if (drain_c) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the skid entry can move.
               if (drain_c) begin
                  state_d   = ST_ONE;
                  out_imm_d = skid_imm_q;
                  out_tag_d = skid_tag_q;
                  out_ill_d = skid_ill_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end

      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_FULL);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         out_imm_q   <= '0;
         out_tag_q   <= '0;
         out_ill_q   <= 1'b0;
         skid_imm_q  <= '0;
         skid_tag_q  <= '0;
         skid_ill_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         out_imm_q   <= out_imm_d;
         out_tag_q   <= out_tag_d;
         out_ill_q   <= out_ill_d;
         skid_imm_q  <= skid_imm_d;
         skid_tag_q  <= skid_tag_d;
         skid_ill_q  <= skid_ill_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign ImmExt      = out_imm_q;
   assign out_tag     = out_tag_q;
   assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: vector table, hand-written skid/flush/reset sequences and
// random traffic checked against a queue-based reference of a 2-deep FIFO.
module tb_imm_ext_pipe;

   typedef struct {
      logic [63:0] imm;
      logic [31:0] tag;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  src;
      logic [31:0] tag;
      logic [31:0] imm;
      logic        ill;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, flush, out_ready;
   logic        in_ready, out_valid, out_illegal;
   logic [31:0] Instr, in_tag, out_tag, ImmExt;
   logic [2:0]  ImmSrc;

   logic        rst_n64, in_valid64, flush64, out_ready64;
   logic        in_ready64, out_valid64, out_illegal64;
   logic [31:0] Instr64, in_tag64, out_tag64;
   logic [63:0] ImmExt64;
   logic [2:0]  ImmSrc64;

   int   checks = 0;
   int   errors = 0;
   exp_t model_q[$];
   logic [31:0] seen[$];
   bit   last_acc;
   vec_t tbl[9];

   always #5 clk = ~clk;

   imm_ext_pipe #(.XLEN(32), .INSTRUCTION_WIDTH(32), .TAG_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .Instr(Instr), .ImmSrc(ImmSrc), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .ImmExt(ImmExt),
      .out_tag(out_tag), .out_illegal(out_illegal)
   );

   imm_ext_pipe #(.XLEN(64), .INSTRUCTION_WIDTH(32), .TAG_WIDTH(32)) dut64 (
      .clk(clk), .rst_n(rst_n64), .in_valid(in_valid64), .in_ready(in_ready64),
      .Instr(Instr64), .ImmSrc(ImmSrc64), .in_tag(in_tag64), .flush(flush64),
      .out_valid(out_valid64), .out_ready(out_ready64), .ImmExt(ImmExt64),
      .out_tag(out_tag64), .out_illegal(out_illegal64)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   function automatic longint fld(input longint x, input int lo, input int n);
      return (x >> lo) & ((longint'(1) << n) - longint'(1));
   endfunction

   function automatic longint sx(input longint v, input int bits);
      if (fld(v, bits - 1, 1) != 0) return v - (longint'(1) << bits);
      return v;
   endfunction

   // Reference immediate from the format definitions, as plain integer arithmetic.
   task automatic ref_imm(input logic [31:0] ins, input logic [2:0] src,
                          output logic [63:0] imm, output logic ill);
      longint x, v;
      x   = longint'({32'd0, ins});
      ill = 1'b0;
      case (src)
         3'd0: v = sx(fld(x, 20, 12), 12);
         3'd1: v = sx((fld(x, 25, 7) << 5) | fld(x, 7, 5), 12);
         3'd2: v = sx((fld(x, 31, 1) << 12) | (fld(x, 7, 1) << 11) |
                      (fld(x, 25, 6) << 5) | (fld(x, 8, 4) << 1), 13);
         3'd3: v = sx(fld(x, 12, 20) << 12, 32);
         3'd4: v = sx((fld(x, 31, 1) << 20) | (fld(x, 12, 8) << 12) |
                      (fld(x, 20, 1) << 11) | (fld(x, 21, 10) << 1), 21);
         3'd5: v = fld(x, 15, 5);
         default: begin v = 0; ill = 1'b1; end
      endcase
      imm = 64'(v);
   endtask

   task automatic check_outputs();
      chk("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
      if (model_q.size() > 0) begin
         chk("ImmExt", 64'(ImmExt), 64'(model_q[0].imm[31:0]));
         chk("out_tag", 64'(out_tag), 64'(model_q[0].tag));
         chk("out_illegal", 64'(out_illegal), 64'(model_q[0].ill));
      end
   endtask

   // One clock of the 32-bit DUT with the model advanced in lock-step.
   task automatic tick();
      bit   acc, drn;
      exp_t e;
      acc = in_valid && (model_q.size() < 2);
      drn = (model_q.size() > 0) && out_ready;
      ref_imm(Instr, ImmSrc, e.imm, e.ill);
      e.tag = in_tag;
      @(posedge clk);
      if (!rst_n || flush) begin
         model_q.delete();
      end else begin
         if (drn) begin
            seen.push_back(model_q[0].tag);
            void'(model_q.pop_front());
         end
         if (acc) model_q.push_back(e);
      end
      last_acc = acc && rst_n && !flush;
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tag);
      in_valid = 1'b1;
      Instr    = ins;
      ImmSrc   = src;
      in_tag   = tag;
   endtask

   initial begin
      tbl[0] = '{32'hFFF00093, 3'b000, 32'h100, 32'hFFFFFFFF, 1'b0};
      tbl[1] = '{32'hFE000EE3, 3'b010, 32'h104, 32'hFFFFFFFC, 1'b0};
      tbl[2] = '{32'h123450B7, 3'b011, 32'h108, 32'h12345000, 1'b0};
      tbl[3] = '{32'h0080006F, 3'b100, 32'h10C, 32'h00000008, 1'b0};
      tbl[4] = '{32'hFFFFFFFF, 3'b110, 32'h110, 32'h00000000, 1'b1};
      tbl[5] = '{32'hFE112E23, 3'b001, 32'h114, 32'hFFFFFFFC, 1'b0};
      tbl[6] = '{32'hFFFF8FFF, 3'b101, 32'h118, 32'h0000001F, 1'b0};
      tbl[7] = '{32'h12345678, 3'b111, 32'h11C, 32'h00000000, 1'b1};
      tbl[8] = '{32'h7FF00013, 3'b000, 32'h120, 32'h000007FF, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      Instr = '0; ImmSrc = '0; in_tag = '0;
      rst_n64 = 1'b0; in_valid64 = 1'b0; flush64 = 1'b0; out_ready64 = 1'b0;
      Instr64 = '0; ImmSrc64 = '0; in_tag64 = '0;

      tick();
      chk("rst_imm", 64'(ImmExt), 64'd0);
      chk("rst_tag", 64'(out_tag), 64'd0);
      chk("rst_ill", 64'(out_illegal), 64'd0);
      rst_n = 1'b1;
      tick();

      // Back-to-back table vectors, one result per cycle.
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].instr, tbl[i].src, tbl[i].tag);
         tick();
         chk("tbl_valid", 64'(out_valid), 64'd1);
         chk("tbl_imm", 64'(ImmExt), 64'(tbl[i].imm));
         chk("tbl_tag", 64'(out_tag), 64'(tbl[i].tag));
         chk("tbl_ill", 64'(out_illegal), 64'(tbl[i].ill));
      end
      in_valid = 1'b0;
      tick();

      // Backpressure: second entry lands in skid, third waits upstream.
      seen.delete();
      out_ready = 1'b0;
      drive(32'hFFF00093, 3'b000, 32'h201); tick();
      drive(32'h123450B7, 3'b011, 32'h202); tick();
      drive(32'h0080006F, 3'b100, 32'h203); tick();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_head_tag", 64'(out_tag), 64'h201);
      out_ready = 1'b1;
      last_acc  = 1'b0;
      for (int k = 0; k < 8 && !last_acc; k++) tick();
      chk("bp_third_accepted", 64'(last_acc), 64'd1);
      in_valid = 1'b0;
      repeat (4) tick();
      chk("bp_count", 64'(seen.size()), 64'd3);
      if (seen.size() == 3) begin
         chk("bp_order0", 64'(seen[0]), 64'h201);
         chk("bp_order1", 64'(seen[1]), 64'h202);
         chk("bp_order2", 64'(seen[2]), 64'h203);
      end

      // Flush while full, with a third entry offered on the same cycle.
      out_ready = 1'b0;
      drive(32'h00100093, 3'b000, 32'h301); tick();
      drive(32'h00200093, 3'b000, 32'h302); tick();
      chk("fl_full", 64'(in_ready), 64'd0);
      seen.delete();
      drive(32'h00300093, 3'b000, 32'h303);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      repeat (4) tick();
      chk("fl_none_seen", 64'(seen.size()), 64'd0);

      // Random traffic with occasional flush and reset.
      for (int n = 0; n < 600; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         rst_n     = ($urandom_range(0, 80) != 0);
         Instr     = $urandom;
         ImmSrc    = 3'($urandom_range(0, 7));
         in_tag    = $urandom;
         tick();
      end
      rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0;
      repeat (3) tick();

      // 64-bit instance: wide sign extension, then reset while full.
      @(posedge clk); #1;
      rst_n64 = 1'b1;
      in_valid64 = 1'b1; out_ready64 = 1'b1;
      Instr64 = 32'hFFF00093; ImmSrc64 = 3'b000; in_tag64 = 32'h40;
      @(posedge clk); #1;
      chk("x64_valid", 64'(out_valid64), 64'd1);
      chk("x64_imm", ImmExt64, 64'hFFFFFFFFFFFFFFFF);
      out_ready64 = 1'b0;
      Instr64 = 32'h123450B7; ImmSrc64 = 3'b011; in_tag64 = 32'h41;
      @(posedge clk); #1;
      chk("x64_full", 64'(in_ready64), 64'd0);
      chk("x64_hold", ImmExt64, 64'hFFFFFFFFFFFFFFFF);
      rst_n64 = 1'b0; out_ready64 = 1'b1;
      @(posedge clk); #1;
      chk("x64_rst_valid", 64'(out_valid64), 64'd0);
      chk("x64_rst_ready", 64'(in_ready64), 64'd1);
      chk("x64_rst_imm", ImmExt64, 64'd0);
      chk("x64_rst_tag", 64'(out_tag64), 64'd0);
      chk("x64_rst_ill", 64'(out_illegal64), 64'd0);
      rst_n64 = 1'b1; in_valid64 = 1'b0;
      @(posedge clk); #1;
      chk("x64_discard", 64'(out_valid64), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
